// File: rtl/dsc_pkg.sv
// Shared constants and sequencer state type for the deterministic stochastic multiplier.
package dsc_pkg;

  localparam int unsigned NUM_BITS   = 10;
  localparam int unsigned NUM_INPUTS = 4;

  typedef enum logic [2:0] {
    IDLE,
    ZERO,
    CLEAR,
    RUN,
    SETTLE,
    DONE
  } seq_state_t;

endpackage

// File: rtl/dsc_mul_seq.sv
// Operand-launch / result-capture sequencer around dsc_mul: accepts one operand set,
// runs the multiplier until ov (or timeout), and returns product and run length.
module dsc_mul_seq
  import dsc_pkg::*;
#(
  parameter int unsigned NUM_BITS = 10,
  parameter int unsigned CYC_W    = 48,
  parameter int unsigned TIMEOUT  = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NUM_BITS-1:0]          in_a,
  input  logic [NUM_BITS-1:0]          in_b,
  input  logic [NUM_BITS-1:0]          in_c,
  input  logic [NUM_BITS-1:0]          in_d,
  output logic                         mul_rst,
  output logic                         mul_en,
  output logic [NUM_BITS-1:0]          mul_a,
  output logic [NUM_BITS-1:0]          mul_b,
  output logic [NUM_BITS-1:0]          mul_c,
  output logic [NUM_BITS-1:0]          mul_d,
  input  logic [NUM_INPUTS*NUM_BITS-1:0] mul_z,
  input  logic                         mul_ov,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NUM_INPUTS*NUM_BITS-1:0] out_z,
  output logic [CYC_W-1:0]             out_cycles,
  output logic                         out_err
);

  localparam int unsigned      ZW      = NUM_INPUTS * NUM_BITS;
  localparam logic [CYC_W-1:0] CYC_MAX = '1;
  localparam logic [CYC_W-1:0] TO_VAL  = CYC_W'(TIMEOUT);

  seq_state_t          state_q, state_d;
  logic [NUM_BITS-1:0] a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
  logic [CYC_W-1:0]    cnt_q, cnt_d, cnt_inc;
  logic [ZW-1:0]       z_q, z_d;
  logic [CYC_W-1:0]    cyc_q, cyc_d;
  logic                err_q, err_d;
  logic                accept, any_zero;

  assign accept   = in_valid && (state_q == IDLE);
  assign any_zero = (in_a == '0) || (in_b == '0) || (in_c == '0) || (in_d == '0);
  assign cnt_inc  = (cnt_q == CYC_MAX) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    z_d     = z_q;
    cyc_d   = cyc_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          a_d     = in_a;
          b_d     = in_b;
          c_d     = in_c;
          d_d     = in_d;
          state_d = any_zero ? ZERO : CLEAR;
        end
      end
      ZERO: begin
        z_d     = '0;
        cyc_d   = '0;
        err_d   = 1'b0;
        state_d = DONE;
      end
      CLEAR: begin
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        cnt_d = cnt_inc;
        // ov takes priority over a timeout landing in the same cycle
        if (mul_ov) begin
          state_d = SETTLE;
        end else if ((TIMEOUT != 0) && (cnt_inc == TO_VAL)) begin
          err_d   = 1'b1;
          z_d     = '0;
          cyc_d   = cnt_inc;
          state_d = DONE;
        end
      end
      SETTLE: begin
        z_d     = mul_z;
        cyc_d   = cnt_q;
        err_d   = 1'b0;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      z_q     <= '0;
      cyc_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      z_q     <= z_d;
      cyc_q   <= cyc_d;
      err_q   <= err_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign mul_en     = (state_q == RUN);
  assign mul_rst    = !((state_q == RUN) || (state_q == SETTLE));
  assign mul_a      = a_q;
  assign mul_b      = b_q;
  assign mul_c      = c_q;
  assign mul_d      = d_q;
  assign out_valid  = (state_q == DONE);
  assign out_z      = z_q;
  assign out_cycles = cyc_q;
  assign out_err    = err_q;

endmodule

// File: tb/tb_dsc_mul_seq.sv
// Bench for dsc_mul_seq: two instances (4-bit no timeout, 10-bit TIMEOUT=5), each with a
// behavioural multiplier stand-in whose run length is chosen per transaction.
module tb_dsc_mul_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- instance A: NUM_BITS=4, TIMEOUT=0 ----------------
  logic        a_in_valid = 1'b0, a_in_ready, a_out_ready = 1'b0;
  logic [3:0]  a_in_a = '0, a_in_b = '0, a_in_c = '0, a_in_d = '0;
  logic        a_mul_rst, a_mul_en, a_out_valid, a_out_err;
  logic [3:0]  a_mul_a, a_mul_b, a_mul_c, a_mul_d;
  logic [15:0] a_mul_z, a_out_z;
  logic [47:0] a_out_cycles;
  logic        a_ov = 1'b0;
  int          a_lat = 1, a_run = 0;
  longint      a_en_tot = 0, a_en0 = 0;

  dsc_mul_seq #(.NUM_BITS(4), .CYC_W(48), .TIMEOUT(0)) u_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_a(a_in_a), .in_b(a_in_b), .in_c(a_in_c), .in_d(a_in_d),
    .mul_rst(a_mul_rst), .mul_en(a_mul_en),
    .mul_a(a_mul_a), .mul_b(a_mul_b), .mul_c(a_mul_c), .mul_d(a_mul_d),
    .mul_z(a_mul_z), .mul_ov(a_ov),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_z(a_out_z), .out_cycles(a_out_cycles), .out_err(a_out_err)
  );

  // Multiplier stand-in: ov rises after a_lat enabled cycles and stays until rst.
  always @(posedge clk) begin
    if (a_mul_rst) begin
      a_run <= 0;
      a_ov  <= 1'b0;
    end else if (a_mul_en && !a_ov) begin
      a_run <= a_run + 1;
      if (a_run + 1 >= a_lat) a_ov <= 1'b1;
    end
    if (a_mul_en) a_en_tot <= a_en_tot + 1;
  end
  assign a_mul_z = a_ov ? 16'(a_mul_a) * 16'(a_mul_b) * 16'(a_mul_c) * 16'(a_mul_d) : 16'h5A5A;

  // ---------------- instance B: NUM_BITS=10, TIMEOUT=5 ----------------
  logic        b_in_valid = 1'b0, b_in_ready, b_out_ready = 1'b0;
  logic [9:0]  b_in_a = '0, b_in_b = '0, b_in_c = '0, b_in_d = '0;
  logic        b_mul_rst, b_mul_en, b_out_valid, b_out_err;
  logic [9:0]  b_mul_a, b_mul_b, b_mul_c, b_mul_d;
  logic [39:0] b_mul_z, b_out_z;
  logic [47:0] b_out_cycles;
  logic        b_ov = 1'b0;
  int          b_lat = 1, b_run = 0;
  longint      b_en_tot = 0;

  dsc_mul_seq #(.NUM_BITS(10), .CYC_W(48), .TIMEOUT(5)) u_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_a(b_in_a), .in_b(b_in_b), .in_c(b_in_c), .in_d(b_in_d),
    .mul_rst(b_mul_rst), .mul_en(b_mul_en),
    .mul_a(b_mul_a), .mul_b(b_mul_b), .mul_c(b_mul_c), .mul_d(b_mul_d),
    .mul_z(b_mul_z), .mul_ov(b_ov),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_z(b_out_z), .out_cycles(b_out_cycles), .out_err(b_out_err)
  );

  always @(posedge clk) begin
    if (b_mul_rst) begin
      b_run <= 0;
      b_ov  <= 1'b0;
    end else if (b_mul_en && !b_ov) begin
      b_run <= b_run + 1;
      if (b_run + 1 >= b_lat) b_ov <= 1'b1;
    end
    if (b_mul_en) b_en_tot <= b_en_tot + 1;
  end
  assign b_mul_z = b_ov ? 40'(b_mul_a) * 40'(b_mul_b) * 40'(b_mul_c) * 40'(b_mul_d) : 40'hA5A5A5A5A5;

  // ---------------- helpers (called at a negedge, return at a negedge) ----------------
  task automatic a_send(input logic [3:0] va, vb, vc, vd, input int lat);
    int guard = 0;
    a_in_a = va; a_in_b = vb; a_in_c = vc; a_in_d = vd;
    a_in_valid = 1'b1;
    while (!a_in_ready && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    chk("a_accept_wait", 64'(a_in_ready), 64'd1);
    a_lat = lat;
    a_en0 = a_en_tot;
    @(negedge clk);
    a_in_valid = 1'b0;
  endtask

  task automatic a_wait_valid();
    int guard = 0;
    while (!a_out_valid && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    chk("a_result_wait", 64'(a_out_valid), 64'd1);
  endtask

  task automatic a_recv(input int stall, output logic [15:0] z, output logic [47:0] cyc,
                        output logic err, output longint en_n);
    a_wait_valid();
    z = a_out_z; cyc = a_out_cycles; err = a_out_err;
    en_n = a_en_tot - a_en0;
    repeat (stall) @(negedge clk);
    a_out_ready = 1'b1;
    @(negedge clk);
    a_out_ready = 1'b0;
    chk("a_no_dup", 64'(a_out_valid), 64'd0);
  endtask

  task automatic b_run_txn(input logic [9:0] va, vb, vc, vd, input int lat,
                           output logic [39:0] z, output logic [47:0] cyc,
                           output logic err, output longint en_n);
    int guard = 0;
    longint en0;
    b_in_a = va; b_in_b = vb; b_in_c = vc; b_in_d = vd;
    b_in_valid = 1'b1;
    b_lat = lat;
    en0 = b_en_tot;
    @(negedge clk);
    b_in_valid = 1'b0;
    while (!b_out_valid && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    chk("b_result_wait", 64'(b_out_valid), 64'd1);
    z = b_out_z; cyc = b_out_cycles; err = b_out_err;
    en_n = b_en_tot - en0;
    b_out_ready = 1'b1;
    @(negedge clk);
    b_out_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [15:0] z;
    logic [39:0] bz;
    logic [47:0] cyc;
    logic        err;
    longint      en_n;
    int          bad;
    logic [63:0] exp_q[$];
    logic [63:0] expv;

    // reset state
    @(negedge clk);
    chk("rst_in_ready", 64'(a_in_ready), 64'd1);
    chk("rst_mul_rst", 64'(a_mul_rst), 64'd1);
    chk("rst_mul_en", 64'(a_mul_en), 64'd0);
    chk("rst_out_valid", 64'(a_out_valid), 64'd0);
    chk("rst_out_z", 64'(a_out_z), 64'd0);
    chk("rst_out_cycles", 64'(a_out_cycles), 64'd0);
    chk("rst_mul_a", 64'(a_mul_a), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: full-scale 4-bit operands
    a_send(4'd15, 4'd15, 4'd15, 4'd15, 7);
    a_recv(0, z, cyc, err, en_n);
    chk("t1_z", 64'(z), 64'd50625);
    chk("t1_err", 64'(err), 64'd0);
    chk("t1_cycles", 64'(cyc), 64'(en_n));

    // 2: zero operand shortcut
    a_send(4'd0, 4'd7, 4'd9, 4'd3, 5);
    chk("t2_valid_early", 64'(a_out_valid), 64'd0);
    @(negedge clk);
    chk("t2_valid_at_2", 64'(a_out_valid), 64'd1);
    a_recv(0, z, cyc, err, en_n);
    chk("t2_z", 64'(z), 64'd0);
    chk("t2_cycles", 64'(cyc), 64'd0);
    chk("t2_err", 64'(err), 64'd0);
    chk("t2_no_en", 64'(en_n), 64'd0);

    // 4: back-pressure with a pending operand set held on the input
    a_send(4'd9, 4'd2, 4'd5, 4'd7, 3);
    a_wait_valid();
    z = a_out_z; cyc = a_out_cycles;
    chk("t4_z", 64'(z), 64'd630);
    a_in_a = 4'd6; a_in_b = 4'd6; a_in_c = 4'd1; a_in_d = 4'd2;
    a_in_valid = 1'b1;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (a_out_z !== z || a_out_cycles !== cyc || a_out_valid !== 1'b1 ||
          a_in_ready !== 1'b0 || a_mul_a !== 4'd9) bad++;
    end
    chk("t4_hold", 64'(bad), 64'd0);
    a_out_ready = 1'b1;
    @(negedge clk);
    a_out_ready = 1'b0;
    chk("t4_ready_after", 64'(a_in_ready), 64'd1);
    a_lat = 2;
    a_en0 = a_en_tot;
    @(negedge clk);
    a_in_valid = 1'b0;
    chk("t4_next_latched", 64'(a_mul_a), 64'd6);
    a_recv(0, z, cyc, err, en_n);
    chk("t4_next_z", 64'(z), 64'd72);

    // 5: asynchronous reset in the middle of a run
    a_send(4'd5, 4'd5, 4'd5, 4'd5, 50);
    repeat (3) @(negedge clk);
    chk("t5_running", 64'(a_mul_en), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_en", 64'(a_mul_en), 64'd0);
    chk("t5_rst", 64'(a_mul_rst), 64'd1);
    chk("t5_valid", 64'(a_out_valid), 64'd0);
    chk("t5_ready", 64'(a_in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    a_send(4'd3, 4'd3, 4'd3, 4'd3, 2);
    a_recv(1, z, cyc, err, en_n);
    chk("t5_z", 64'(z), 64'd81);

    // 3: timeout and ov/timeout collision on the 10-bit instance
    b_run_txn(10'd1023, 10'd1023, 10'd1023, 10'd1023, 100, bz, cyc, err, en_n);
    chk("t3_err", 64'(err), 64'd1);
    chk("t3_z", 64'(bz), 64'd0);
    chk("t3_cycles", 64'(cyc), 64'd5);
    chk("t3_en", 64'(en_n), 64'd5);
    b_run_txn(10'd1000, 10'd999, 10'd7, 10'd3, 4, bz, cyc, err, en_n);
    chk("t3_tie_err", 64'(err), 64'd0);
    chk("t3_tie_z", 64'(bz), 64'd1000 * 64'd999 * 64'd7 * 64'd3);
    chk("t3_tie_cycles", 64'(cyc), 64'd5);
    b_run_txn(10'd12, 10'd34, 10'd56, 10'd78, 3, bz, cyc, err, en_n);
    chk("t3_ok_err", 64'(err), 64'd0);
    chk("t3_ok_z", 64'(bz), 64'd12 * 64'd34 * 64'd56 * 64'd78);
    chk("t3_ok_cycles", 64'(cyc), 64'(en_n));

    // 6: random back-to-back traffic with random output stalls
    for (int i = 0; i < 100; i++) begin
      logic [3:0] va, vb, vc, vd;
      va = 4'($urandom_range(1, 15));
      vb = 4'($urandom_range(1, 15));
      vc = 4'($urandom_range(1, 15));
      vd = 4'($urandom_range(1, 15));
      exp_q.push_back(64'(va) * 64'(vb) * 64'(vc) * 64'(vd));
      a_send(va, vb, vc, vd, int'($urandom_range(1, 6)));
      a_recv(int'($urandom_range(0, 3)), z, cyc, err, en_n);
      expv = exp_q.pop_front();
      chk("t6_z", 64'(z), expv);
      chk("t6_cycles", 64'(cyc), 64'(en_n));
      chk("t6_err", 64'(err), 64'd0);
    end
    chk("t6_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
